// File: rtl/alu_pkg.sv
// Opcodes, FSM states and helpers shared by the ALU sequencing stage.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_EQ  = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Comparisons produce a flag, not a value worth keeping in the accumulator.
   function automatic logic is_cmp_op(input logic [2:0] op);
      return (op == OP_LT) || (op == OP_EQ);
   endfunction

endpackage

// File: rtl/alu_step_res_reg.sv
// Result capture/hold register: loads ALU outputs at EXEC and holds them until released downstream.
// Latency 1 cycle from capture; res_valid drops only on release. Macro ALU_STEP_STICKY_OVF_EN makes overflow sticky.
module alu_step_res_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_capture,
   input  logic             i_release,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_alu_s,
   input  logic             i_alu_c,
   input  logic             i_alu_zero,
   input  logic             i_alu_ovf,
   output logic             o_res_valid,
   output logic [WIDTH-1:0] o_res_s,
   output logic             o_res_c,
   output logic             o_res_zero,
   output logic             o_res_ovf
);

   logic             r_valid;
   logic [WIDTH-1:0] r_s;
   logic             r_c;
   logic             r_zero;
   logic             r_ovf;
   logic             w_ovf_next;

`ifdef ALU_STEP_STICKY_OVF_EN
   // Accumulates overflow across operations until the accumulator is cleared.
   assign w_ovf_next = r_ovf | i_alu_ovf;
`else
   assign w_ovf_next = i_alu_ovf;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_s     <= '0;
         r_c     <= 1'b0;
         r_zero  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (i_capture) begin
            r_valid <= 1'b1;
            r_s     <= i_alu_s;
            r_c     <= i_alu_c;
            r_zero  <= i_alu_zero;
            r_ovf   <= w_ovf_next;
         end else if (i_release) begin
            r_valid <= 1'b0;
         end
`ifdef ALU_STEP_STICKY_OVF_EN
         if (i_clr) begin
            r_ovf <= 1'b0;
         end
`endif
      end
   end

`ifndef ALU_STEP_STICKY_OVF_EN
   // Clear only matters for the sticky flag.
   logic w_unused_clr;
   assign w_unused_clr = i_clr;
`endif

   assign o_res_valid = r_valid;
   assign o_res_s     = r_s;
   assign o_res_c     = r_c;
   assign o_res_zero  = r_zero;
   assign o_res_ovf   = r_ovf;

endmodule

// File: rtl/alu_step_ctrl.sv
// Accumulator sequencer around a combinational ALU: registers operands, captures result, writes back acc.
// Latency: result valid 2 edges after accept; cmd_ready low from accept until the result handshake completes.
// Optional macro ALU_STEP_STICKY_OVF_EN makes res_ovf sticky until clear/reset.
module alu_step_ctrl
   import alu_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter int               OP_W     = 3,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_imm,
   input  logic             cmd_use_imm_x,
   input  logic             cmd_clr,
   output logic [OP_W-1:0]  alu_op,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   input  logic [WIDTH-1:0] alu_s,
   input  logic             alu_c,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_s,
   output logic             res_c,
   output logic             res_zero,
   output logic             res_ovf,
   output logic [WIDTH-1:0] acc
);

   state_t           r_state;
   state_t           w_next;
   logic [OP_W-1:0]  r_alu_op;
   logic [WIDTH-1:0] r_alu_x;
   logic [WIDTH-1:0] r_alu_y;
   logic [WIDTH-1:0] r_acc;
   logic             w_accept;
   logic             w_clr;
   logic             w_start;
   logic             w_capture;
   logic             w_release;
   logic             w_res_valid;

   assign cmd_ready = (r_state == IDLE);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_clr     = w_accept && cmd_clr;
   assign w_start   = w_accept && !cmd_clr;
   assign w_capture = (r_state == EXEC);
   assign w_release = (r_state == HOLD) && res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = EXEC;
         EXEC:    w_next = HOLD;
         HOLD:    if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Operands stay frozen through HOLD because new commands are only taken in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_op <= '0;
         r_alu_x  <= '0;
         r_alu_y  <= '0;
      end else if (w_start) begin
         r_alu_op <= cmd_op;
         r_alu_x  <= cmd_use_imm_x ? cmd_imm : r_acc;
         r_alu_y  <= cmd_use_imm_x ? r_acc   : cmd_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= ACC_INIT;
      end else if (w_clr) begin
         r_acc <= ACC_INIT;
      end else if (w_capture && !is_cmp_op(r_alu_op)) begin
         r_acc <= alu_s;
      end
   end

   alu_step_res_reg #(
      .WIDTH (WIDTH)
   ) u_res_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_capture   (w_capture),
      .i_release   (w_release),
      .i_clr       (w_clr),
      .i_alu_s     (alu_s),
      .i_alu_c     (alu_c),
      .i_alu_zero  (alu_zero),
      .i_alu_ovf   (alu_ovf),
      .o_res_valid (w_res_valid),
      .o_res_s     (res_s),
      .o_res_c     (res_c),
      .o_res_zero  (res_zero),
      .o_res_ovf   (res_ovf)
   );

   assign res_valid = w_res_valid;
   assign alu_op    = r_alu_op;
   assign alu_x     = r_alu_x;
   assign alu_y     = r_alu_y;
   assign acc       = r_acc;

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Directed bench for alu_step_ctrl with a behavioural 4-bit ALU closing the loop.
module tb_alu_step_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'b000;
   logic [3:0] cmd_imm = 4'h0;
   logic       cmd_use_imm_x = 1'b0;
   logic       cmd_clr = 1'b0;
   logic [2:0] alu_op;
   logic [3:0] alu_x, alu_y, alu_s;
   logic       alu_c, alu_zero, alu_ovf;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_s;
   logic       res_c, res_zero, res_ovf;
   logic [3:0] acc;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_step_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
      .cmd_use_imm_x(cmd_use_imm_x), .cmd_clr(cmd_clr),
      .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
      .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_s(res_s), .res_c(res_c), .res_zero(res_zero), .res_ovf(res_ovf),
      .acc(acc)
   );

   // Reference ALU: add/sub carry out of bit 3 (sub: borrow), signed overflow, unsigned compare.
   logic [4:0] alu_t;
   always_comb begin
      alu_t   = 5'd0;
      alu_ovf = 1'b0;
      case (alu_op)
         3'b000: begin
            alu_t   = {1'b0, alu_x} + {1'b0, alu_y};
            alu_ovf = (alu_x[3] == alu_y[3]) && (alu_t[3] != alu_x[3]);
         end
         3'b001: begin
            alu_t   = {1'b0, alu_x} - {1'b0, alu_y};
            alu_ovf = (alu_x[3] != alu_y[3]) && (alu_t[3] != alu_x[3]);
         end
         3'b010:  alu_t = {1'b0, ~alu_x};
         3'b011:  alu_t = {1'b0, alu_x & alu_y};
         3'b100:  alu_t = {1'b0, alu_x | alu_y};
         3'b101:  alu_t = {1'b0, alu_x ^ alu_y};
         3'b110:  alu_t = {4'd0, alu_x < alu_y};
         default: alu_t = {4'd0, alu_x == alu_y};
      endcase
      alu_s    = alu_t[3:0];
      alu_c    = alu_t[4];
      alu_zero = (alu_t[3:0] == 4'd0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one command for one edge; returns just after the accept edge.
   task automatic accept_cmd(input logic [2:0] op, input logic [3:0] imm, input logic ux, input logic clr);
      cmd_op = op; cmd_imm = imm; cmd_use_imm_x = ux; cmd_clr = clr; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0; cmd_clr = 1'b0;
   endtask

   // Full command: accept, EXEC edge; returns in HOLD with the result presented.
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] imm, input logic ux);
      accept_cmd(op, imm, ux, 1'b0);
      tick();
   endtask

   task automatic release_res();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_chk++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0h exp 0", res_valid); end
      n_chk++; if (acc !== 4'h0) begin n_err++; $display("FAIL reset_acc: got %0h exp 0", acc); end
      n_chk++; if ({alu_op, alu_x, alu_y} !== 11'd0) begin n_err++; $display("FAIL reset_alu_regs: got %0h exp 0", {alu_op, alu_x, alu_y}); end
      n_chk++; if ({res_s, res_c, res_zero, res_ovf} !== 7'd0) begin n_err++; $display("FAIL reset_res: got %0h exp 0", {res_s, res_c, res_zero, res_ovf}); end
      n_chk++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %0h exp 1", cmd_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      accept_cmd(3'b000, 4'h3, 1'b0, 1'b0);
      n_chk++; if ({alu_x, alu_y} !== 8'h03) begin n_err++; $display("FAIL add_operands: got %0h exp 03", {alu_x, alu_y}); end
      n_chk++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_early: got %0h exp 0", res_valid); end
      n_chk++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL add_ready_exec: got %0h exp 0", cmd_ready); end
      tick();
      n_chk++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0h exp 1", res_valid); end
      n_chk++; if ({res_s, res_zero} !== 5'b0011_0) begin n_err++; $display("FAIL add_res: got %0h exp 06", {res_s, res_zero}); end
      n_chk++; if (acc !== 4'h3) begin n_err++; $display("FAIL add_acc: got %0h exp 3", acc); end
      release_res();
      n_chk++; if ({res_valid, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL add_release: got %0h exp 1", {res_valid, cmd_ready}); end
   endtask

   task automatic test_ovf();
      logic exp_sticky;
      run_cmd(3'b000, 4'h4, 1'b0);
      release_res();
      n_chk++; if (acc !== 4'h7) begin n_err++; $display("FAIL ovf_setup_acc: got %0h exp 7", acc); end
      run_cmd(3'b000, 4'h1, 1'b0);
      n_chk++; if ({res_s, res_c, res_ovf} !== 6'b1000_0_1) begin n_err++; $display("FAIL ovf_add: got %0h exp 21", {res_s, res_c, res_ovf}); end
      n_chk++; if (acc !== 4'h8) begin n_err++; $display("FAIL ovf_acc: got %0h exp 8", acc); end
      release_res();
`ifdef ALU_STEP_STICKY_OVF_EN
      exp_sticky = 1'b1;
`else
      exp_sticky = 1'b0;
`endif
      run_cmd(3'b000, 4'h0, 1'b0);
      n_chk++; if (res_ovf !== exp_sticky) begin n_err++; $display("FAIL ovf_next_op: got %0h exp %0h", res_ovf, exp_sticky); end
      n_chk++; if (res_s !== 4'h8) begin n_err++; $display("FAIL ovf_next_res: got %0h exp 8", res_s); end
      release_res();
   endtask

   task automatic test_eq_sub();
      accept_cmd(3'b000, 4'h0, 1'b0, 1'b1);
      run_cmd(3'b000, 4'h5, 1'b0);
      n_chk++; if ({acc, res_ovf} !== 5'b0101_0) begin n_err++; $display("FAIL clr_then_add: got %0h exp 0a", {acc, res_ovf}); end
      release_res();
      run_cmd(3'b111, 4'h5, 1'b0);
      n_chk++; if ({res_s, acc} !== 8'h15) begin n_err++; $display("FAIL eq: got %0h exp 15", {res_s, acc}); end
      release_res();
      run_cmd(3'b001, 4'h5, 1'b0);
      n_chk++; if ({res_s, res_zero, acc} !== 9'b0000_1_0000) begin n_err++; $display("FAIL sub_zero: got %0h exp 10", {res_s, res_zero, acc}); end
      release_res();
      accept_cmd(3'b001, 4'h2, 1'b1, 1'b0);
      n_chk++; if ({alu_x, alu_y} !== 8'h20) begin n_err++; $display("FAIL sub_imm_x_operands: got %0h exp 20", {alu_x, alu_y}); end
      tick();
      n_chk++; if ({res_s, res_c, acc} !== 9'b0010_0_0010) begin n_err++; $display("FAIL sub_imm_x: got %0h exp 42", {res_s, res_c, acc}); end
      release_res();
      run_cmd(3'b110, 4'h9, 1'b0);
      n_chk++; if ({res_s, acc} !== 8'h12) begin n_err++; $display("FAIL lt: got %0h exp 12", {res_s, acc}); end
      release_res();
   endtask

   task automatic test_hold();
      run_cmd(3'b000, 4'h1, 1'b0);
      cmd_op = 3'b000; cmd_imm = 4'hf; cmd_use_imm_x = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_chk++; if ({res_valid, cmd_ready, res_s, alu_y} !== 10'b1_0_0011_0001) begin
            n_err++; $display("FAIL hold_cycle%0d: got %0h exp 231", i, {res_valid, cmd_ready, res_s, alu_y});
         end
         tick();
      end
      cmd_valid = 1'b0;
      release_res();
      n_chk++; if ({res_valid, cmd_ready, acc} !== 6'b0_1_0011) begin n_err++; $display("FAIL hold_release: got %0h exp 13", {res_valid, cmd_ready, acc}); end
   endtask

   task automatic test_ignore_ready();
      res_ready = 1'b1;
      tick();
      run_cmd(3'b000, 4'h4, 1'b0);
      n_chk++; if ({res_valid, res_s} !== 5'b1_0111) begin n_err++; $display("FAIL ready_early: got %0h exp 17", {res_valid, res_s}); end
      tick();
      res_ready = 1'b0;
      n_chk++; if ({res_valid, cmd_ready, acc} !== 6'b0_1_0111) begin n_err++; $display("FAIL ready_early_release: got %0h exp 17", {res_valid, cmd_ready, acc}); end
   endtask

   task automatic test_reset_mid();
      run_cmd(3'b000, 4'h2, 1'b0);
      release_res();
      n_chk++; if (acc !== 4'h9) begin n_err++; $display("FAIL rst_setup_acc: got %0h exp 9", acc); end
      accept_cmd(3'b000, 4'h1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_chk++; if ({res_valid, acc, cmd_ready} !== 6'b0_0000_1) begin n_err++; $display("FAIL rst_mid_exec: got %0h exp 01", {res_valid, acc, cmd_ready}); end
      n_chk++; if ({alu_x, alu_y} !== 8'h00) begin n_err++; $display("FAIL rst_mid_alu: got %0h exp 00", {alu_x, alu_y}); end
      #2;
      rst_n = 1'b1;
      tick();
      n_chk++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_after: got %0h exp 0", res_valid); end
   endtask

   task automatic test_clr();
      run_cmd(3'b000, 4'h6, 1'b0);
      release_res();
      cmd_clr = 1'b1;
      tick();
      cmd_clr = 1'b0;
      n_chk++; if (acc !== 4'h6) begin n_err++; $display("FAIL clr_no_valid: got %0h exp 6", acc); end
      accept_cmd(3'b000, 4'h0, 1'b0, 1'b1);
      n_chk++; if ({acc, cmd_ready} !== 5'b0000_1) begin n_err++; $display("FAIL clr_acc: got %0h exp 01", {acc, cmd_ready}); end
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL clr_no_result%0d: got %0h exp 0", i, res_valid); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ovf();
      test_eq_sub();
      test_hold();
      test_ignore_ready();
      test_reset_mid();
      test_clr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
